// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command handshake between host and alu_sequencer
interface alu_sequencer_if #(
  parameter int AW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_rd;

  modport master (output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, output cmd_ready);
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - register file plus issue/wait/writeback sequencer for the registered ALU
module alu_sequencer #(
  parameter int N    = 8,
  parameter int REGS = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_sequencer_if.slave cmd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic [N-1:0]  alu_A,
  output logic [N-1:0]  alu_B,
  output logic [3:0]    alu_s,
  input  logic [N-1:0]  alu_F,
  input  logic          alu_G,
  input  logic          alu_E,
  input  logic          alu_L,
  input  logic          alu_Zero,
  input  logic          alu_carryOut,
  input  logic          alu_Overflow,
  output logic          done,
  output logic [N-1:0]  res_F,
  output logic [5:0]    flags,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  regs [REGS];
  logic [AW-1:0] rd_q;
  logic [N-1:0]  res_q;
  logic [5:0]    flags_q;
  logic          accept;

  // rst gates ready so nothing is offered while the block is held in reset
  assign cmd.cmd_ready = (state_q == IDLE) && rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == WB);
  assign rd_data       = regs[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      alu_A   <= '0;
      alu_B   <= '0;
      alu_s   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      res_F   <= '0;
      flags   <= '0;
    end else begin
      // operands come from the pre-edge regfile, so a same-cycle host write is not seen
      if (accept) begin
        alu_A <= regs[cmd.cmd_ra];
        alu_B <= regs[cmd.cmd_rb];
        alu_s <= cmd.cmd_op;
        rd_q  <= cmd.cmd_rd;
      end
      if (state_q == ISSUE) begin
        flags_q <= {alu_G, alu_E, alu_L, alu_Zero, alu_carryOut, alu_Overflow};
      end
      if (state_q == WAIT) begin
        res_q <= alu_F;
      end
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
      // later assignment makes the writeback win over a host write to the same index
      if (state_q == WB) begin
        regs[rd_q] <= res_q;
        res_F      <= res_q;
        flags      <= flags_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - table, hand-written and randomized checks of alu_sequencer
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [7:0] alu_A, alu_B, alu_F;
  logic [3:0] alu_s;
  logic       alu_G, alu_E, alu_L, alu_Zero, alu_carryOut, alu_Overflow;
  logic       done, busy;
  logic [7:0] res_F;
  logic [5:0] flags;
  logic [5:0] alu_fl;

  int total = 0;
  int bad   = 0;
  logic [7:0] refr [4];

  alu_sequencer_if #(.AW(2)) cmd_if ();

  alu_sequencer #(.N(8), .REGS(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_s(alu_s), .alu_F(alu_F),
    .alu_G(alu_G), .alu_E(alu_E), .alu_L(alu_L), .alu_Zero(alu_Zero),
    .alu_carryOut(alu_carryOut), .alu_Overflow(alu_Overflow),
    .done(done), .res_F(res_F), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [5:0] flags_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ua, ub, sa, sb, sr;
    logic c, o, g, e, l, z;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    o = 1'b0;
    if (op == 4'd0) begin
      sr = sa + sb;
      c  = (ua + ub) > 255;
      o  = (sr > 127) || (sr < -128);
    end else if (op == 4'd1) begin
      sr = sa - sb;
      c  = ua < ub;
      o  = (sr > 127) || (sr < -128);
    end
    g = ua > ub;
    e = ua == ub;
    l = ua < ub;
    z = f_ref(a, b, op) == 8'h00;
    return {g, e, l, z, c, o};
  endfunction

  // behavioural ALU: result registered one cycle, flags combinational
  assign alu_fl = flags_ref(alu_A, alu_B, alu_s);
  assign {alu_G, alu_E, alu_L, alu_Zero, alu_carryOut, alu_Overflow} = alu_fl;
  always_ff @(posedge clk) alu_F <= f_ref(alu_A, alu_B, alu_s);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hwrite(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    refr[a] = d;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk($sformatf("%s_r%0d", tag, i), {24'h0, v}, {24'h0, refr[i]});
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd_i, input bit do_wr, input int wr_k,
                         input logic [1:0] wa, input logic [7:0] wd, input string tag);
    logic [7:0] opa, opb, exp_f;
    logic [5:0] exp_fl;
    int lat;
    int waited;
    waited = 0;
    while (!cmd_if.cmd_ready && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_if.cmd_ready) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    opa    = refr[ra];
    opb    = refr[rb];
    exp_f  = f_ref(opa, opb, op);
    exp_fl = flags_ref(opa, opb, op);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_ra    = ra;
    cmd_if.cmd_rb    = rb;
    cmd_if.cmd_rd    = rd_i;
    if (do_wr && wr_k == 0) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
    end
    lat = -1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      cmd_if.cmd_valid = 1'b0;
      wr_en = 1'b0;
      if (do_wr && wr_k == cyc) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      if (cyc == 1) begin
        chk({tag, "_issue_A"}, {24'h0, alu_A}, {24'h0, opa});
        chk({tag, "_issue_B"}, {24'h0, alu_B}, {24'h0, opb});
        chk({tag, "_issue_s"}, {28'h0, alu_s}, {28'h0, op});
        chk({tag, "_ready_busy"}, {31'h0, cmd_if.cmd_ready}, 0);
      end
      if (lat >= 0) begin
        chk({tag, "_done_width"}, {31'h0, done}, 0);
        break;
      end
      if (done) lat = cyc;
    end
    chk({tag, "_latency"}, lat, 3);
    if (do_wr) refr[wa] = wd;
    refr[rd_i] = exp_f;
    chk({tag, "_res_F"}, {24'h0, res_F}, {24'h0, exp_f});
    chk({tag, "_flags"}, {26'h0, flags}, {26'h0, exp_fl});
    check_regs(tag);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic [3:0] op;
    logic [1:0] ra, rb, rd;
    logic [7:0] exp_f;
    logic [5:0] exp_fl;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [7:0] v;
    int n;

    tbl[0] = '{8'h05, 8'h03, 4'd0, 2'd1, 2'd2, 2'd0, 8'h08, 6'b100000};
    tbl[1] = '{8'h80, 8'h01, 4'd1, 2'd1, 2'd2, 2'd3, 8'h7F, 6'b100001};
    tbl[2] = '{8'hFF, 8'h01, 4'd0, 2'd2, 2'd3, 2'd2, 8'h00, 6'b100110};
    tbl[3] = '{8'h7F, 8'h01, 4'd0, 2'd0, 2'd1, 2'd1, 8'h80, 6'b100001};
    tbl[4] = '{8'h03, 8'h05, 4'd1, 2'd3, 2'd0, 2'd3, 8'hFE, 6'b001010};
    tbl[5] = '{8'h42, 8'h42, 4'd1, 2'd2, 2'd2, 2'd1, 8'h00, 6'b010100};
    tbl[6] = '{8'hF0, 8'h3C, 4'd2, 2'd0, 2'd1, 2'd2, 8'h30, 6'b100000};

    rst = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0;
    cmd_if.cmd_ra = '0; cmd_if.cmd_rb = '0; cmd_if.cmd_rd = '0;
    for (int i = 0; i < 4; i++) refr[i] = 8'h00;

    #3;
    chk("rst_cmd_ready", {31'h0, cmd_if.cmd_ready}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_alu_A", {24'h0, alu_A}, 0);
    chk("rst_alu_s", {28'h0, alu_s}, 0);
    chk("rst_res_F", {24'h0, res_F}, 0);
    chk("rst_flags", {26'h0, flags}, 0);
    @(posedge clk); @(posedge clk); #5;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'h0, cmd_if.cmd_ready}, 1);
    check_regs("post_rst");

    for (int i = 0; i < 7; i++) begin
      hwrite(tbl[i].ra, tbl[i].a);
      hwrite(tbl[i].rb, tbl[i].b);
      run_cmd(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rd, 1'b0, 0, 2'd0, 8'h00, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_exp_res", i), {24'h0, res_F}, {24'h0, tbl[i].exp_f});
      chk($sformatf("tbl%0d_exp_flags", i), {26'h0, flags}, {26'h0, tbl[i].exp_fl});
      rd(tbl[i].rd, v);
      chk($sformatf("tbl%0d_exp_rd", i), {24'h0, v}, {24'h0, tbl[i].exp_f});
    end

    // back-to-back with cmd_valid held: second command must see the first's writeback
    hwrite(2'd1, 8'h05);
    hwrite(2'd2, 8'h03);
    hwrite(2'd0, 8'h11);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 4'd0;
    cmd_if.cmd_ra = 2'd1; cmd_if.cmd_rb = 2'd2; cmd_if.cmd_rd = 2'd0;
    @(posedge clk); #1;
    cmd_if.cmd_ra = 2'd0; cmd_if.cmd_rd = 2'd3;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("b2b_ready_c%0d", c), {31'h0, cmd_if.cmd_ready}, 0);
      if (c == 2) chk("b2b_hold_A", {24'h0, alu_A}, 32'h05);
      @(posedge clk); #1;
    end
    chk("b2b_ready_c4", {31'h0, cmd_if.cmd_ready}, 1);
    chk("b2b_done_c4", {31'h0, done}, 0);
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    chk("b2b_second_busy", {31'h0, busy}, 1);
    chk("b2b_second_A", {24'h0, alu_A}, 32'h08);
    chk("b2b_second_B", {24'h0, alu_B}, 32'h03);
    n = 0;
    while (!done && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_done_seen", {31'h0, done}, 1);
    @(posedge clk); #1;
    refr[0] = 8'h08;
    refr[3] = 8'h0B;
    check_regs("b2b");

    // host write colliding with writeback
    run_cmd(4'd0, 2'd1, 2'd2, 2'd0, 1'b1, 3, 2'd0, 8'hAA, "coll_same");
    rd(2'd0, v);
    chk("coll_same_r0", {24'h0, v}, 32'h08);
    run_cmd(4'd0, 2'd1, 2'd2, 2'd0, 1'b1, 3, 2'd1, 8'hAA, "coll_diff");
    rd(2'd0, v);
    chk("coll_diff_r0", {24'h0, v}, 32'h08);
    rd(2'd1, v);
    chk("coll_diff_r1", {24'h0, v}, 32'hAA);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) hwrite(2'($urandom_range(0, 3)), 8'($urandom));
      run_cmd(4'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 8'($urandom), $sformatf("rnd%0d", k));
    end

    // reset during WAIT drops the command
    hwrite(2'd1, 8'h21);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 4'd0;
    cmd_if.cmd_ra = 2'd1; cmd_if.cmd_rb = 2'd1; cmd_if.cmd_rd = 2'd2;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_before", {31'h0, busy}, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) refr[i] = 8'h00;
    #1;
    chk("midrst_busy", {31'h0, busy}, 0);
    chk("midrst_ready", {31'h0, cmd_if.cmd_ready}, 0);
    chk("midrst_res_F", {24'h0, res_F}, 0);
    check_regs("midrst");
    n = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    if (done) n++;
    chk("midrst_no_done", n, 0);
    chk("midrst_ready_after", {31'h0, cmd_if.cmd_ready}, 1);
    chk("midrst_busy_after", {31'h0, busy}, 0);
    run_cmd(4'd1, 2'd0, 2'd0, 2'd1, 1'b0, 0, 2'd0, 8'h00, "post_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side initiator for the registered 8-bit ALU.
- Holds a small operand register file and accepts op commands over a valid/ready handshake.
- For each command it drives operands and select onto the ALU, waits out the ALU's one-cycle output register, then writes the result back into the register file and latches the flags.
- Sits between a host/controller and the ALU top level; shares the ALU's clock and reset.

Parameters:
- N, 8, operand/result width (matches ALU width).
- REGS, 4, number of register-file entries.
- AW, 2, register index width; must satisfy 2**AW == REGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  4  ALU select code, passed unmodified to alu_s.
- cmd_ra  input  AW  source register for operand A.
- cmd_rb  input  AW  source register for operand B.
- cmd_rd  input  AW  destination register.
- wr_en  input  1  host register-file write strobe.
- wr_addr  input  AW  host write index.
- wr_data  input  N  host write data.
- rd_addr  input  AW  host read index.
- rd_data  output  N  combinational read of regfile[rd_addr].
- alu_A  output  N  operand A to ALU.
- alu_B  output  N  operand B to ALU.
- alu_s  output  4  select to ALU.
- alu_F  input  N  ALU registered result.
- alu_G, alu_E, alu_L, alu_Zero, alu_carryOut, alu_Overflow  input  1 each  ALU flags, combinational from the current A/B/s.
- done  output  1  one-cycle pulse when writeback occurs.
- res_F  output  N  last written-back result.
- flags  output  6  last latched flags, ordered {G,E,L,Zero,carryOut,Overflow} MSB..LSB.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all regfile entries=0.
  - alu_A, alu_B, alu_s, res_F, flags = 0.
  - done=0, busy=0.
  - cmd_ready=0 while rst is low.
- FSM states are IDLE, ISSUE, WAIT, WB.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at a clock edge:
    - capture alu_A=reg[cmd_ra], alu_B=reg[cmd_rb], alu_s=cmd_op, rd_q=cmd_rd;
    - go to ISSUE.
  - ISSUE: operands stable on alu_A/alu_B/alu_s. At the end of this cycle:
    - latch the 6 flag inputs into flags_q (flags are combinational, so they are valid now);
    - the ALU register captures its result on the same edge;
    - go to WAIT.
  - WAIT: alu_F now holds the result. At the end of this cycle:
    - capture res_q=alu_F;
    - go to WB.
  - WB:
    - regfile[rd_q]=res_q; res_F=res_q; flags=flags_q; done=1 for this cycle only;
    - go to IDLE.
- Latency:
  - Accept edge at cycle 0, done high in cycle 3.
  - Next accept is possible at the end of cycle 4 (one IDLE cycle), so throughput is 1 command per 4 cycles.
- alu_A/alu_B/alu_s hold their last values in WAIT, WB and IDLE; they change only on accept.
- Operand read hazards:
  - Operands are read from the regfile at accept time.
  - A host write in the same cycle as an accept is not forwarded; the old value is used.
- Host writes:
  - Accepted in any state.
  - If a host write and the WB writeback target the same index in the same cycle, the writeback wins.
  - Writes to different indices in the same cycle both take effect.
- rd_data reflects regfile contents after the last edge; no bypass.
- ra==rb and rd==ra/rb are legal; rd is overwritten only in WB.
- cmd_* inputs are ignored while cmd_ready=0. Commands are never queued.
- Reset asserted mid-operation: the in-flight command is dropped, no done pulse, and the regfile clears.
- All arithmetic is performed by the ALU; this block does no width conversion (N bits in, N bits back).

Test Plan:
- Bench uses a behavioural ALU model:
  - F registered one cycle after A/B/s;
  - flags combinational;
  - s=0 gives F=A+B, s=1 gives F=A-B.
- Reset then host writes R1=5, R2=3; command op=0, ra=1, rb=2, rd=0 -> alu_A=5, alu_B=3 in ISSUE; done in cycle 3; R0=8, res_F=8, flags match the model for 5,3.
- Signed subtract: R1=8'h80, R2=8'h01, op=1, rd=3 -> R3=8'h7F, Overflow bit of flags=1, E=0.
- Back-to-back: cmd_valid held high with two commands -> second accepted exactly 4 cycles after the first; cmd_ready=0 in cycles 1-3; second command reads the first command's written-back value (R0=8 used as A).
- Collision: in the WB cycle, host writes R0=8'hAA while writeback targets R0=8'h08 -> R0=8'h08; repeat with host wr_addr=1 -> R0=8'h08 and R1=8'hAA.
- Reset mid-op: assert rst=0 during WAIT -> busy=0 immediately, no done pulse, rd_data=0 for all indices, cmd_ready=1 on the first edge after rst returns to 1.
